// File: rtl/mac_accumulator_block_pkg.sv
// Shared constants for the MAC accumulation stage: mode encodings, cfg bit
// positions and the accumulator FSM state type.
package mac_accumulator_block_pkg;

    localparam logic [1:0] MAC_MODE_SINGLE = 2'b00;
    localparam logic [1:0] MAC_MODE_DUAL   = 2'b01;
    localparam logic [1:0] MAC_MODE_QUAD   = 2'b10;

    localparam int MAC_CFG_SIGNED_BIT = 3;
    localparam int MAC_CFG_MAC_BIT    = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/mac_acc_lane_adder.sv
// One accumulator lane: W-bit add with carry in, carry out and the carry
// into the MSB (needed for signed overflow detection).
module mac_acc_lane_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    assign cmsb = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/mac_accumulator_block.sv
// Segmented 128-bit accumulator (4x32 / 2x64 / 1x128) with a beat counter
// and cfg latch. Define MAC_ACC_OVERFLOW_EN to add sticky per-segment ovf.
module mac_accumulator_block
    import mac_accumulator_block_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int MAC_CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    input  logic                      valid_in,
    input  logic                      clear,
    input  logic [MAC_ACC_WIDTH-1:0]  C0_in,
    input  logic [MAC_ACC_WIDTH-1:0]  C1_in,
    input  logic [MAC_ACC_WIDTH-1:0]  C2_in,
    input  logic [MAC_ACC_WIDTH-1:0]  C3_in,
    output logic [MAC_ACC_WIDTH-1:0]  acc0,
    output logic [MAC_ACC_WIDTH-1:0]  acc1,
    output logic [MAC_ACC_WIDTH-1:0]  acc2,
    output logic [MAC_ACC_WIDTH-1:0]  acc3,
    output logic                      valid_out,
    output logic [MAC_CNT_WIDTH-1:0]  acc_count,
    output logic [MAC_CONF_WIDTH-1:0] cfg_active,
    output logic                      fsm_state
`ifdef MAC_ACC_OVERFLOW_EN
    ,
    output logic [3:0]                ovf
`endif
);

    if (MAC_ACC_WIDTH % MAC_MIN_WIDTH != 0) begin : g_width_check
        $error("MAC_ACC_WIDTH must be a multiple of MAC_MIN_WIDTH");
    end

    // Handshake: valid_in qualifies C*_in on an edge with en=1; there is no
    // ready. valid_out is high the cycle after, when acc already holds that beat.

    acc_state_e state_q, state_d;
    logic fire, do_load, do_beat, do_add, do_clear;
    logic [1:0] mode;
    logic [MAC_ACC_WIDTH-1:0] sum0, sum1, sum2, sum3;
    logic cout0, cout1, cout2, cout3;
    logic cmsb0, cmsb1, cmsb2, cmsb3;
    logic cin1, cin2, cin3;

    assign fsm_state = state_q;
    assign mode      = cfg_active[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            if (valid_in)   state_d = ST_ACC;
            else if (clear) state_d = ST_IDLE;
        end
    end

    // A clear with a beat in the same cycle behaves exactly like an IDLE load.
    always_comb begin
        fire     = en & valid_in;
        do_load  = fire & ((state_q == ST_IDLE) | clear);
        do_beat  = fire & ~do_load;
        do_add   = do_beat & cfg_active[MAC_CFG_MAC_BIT];
        do_clear = en & clear & ~valid_in;
    end

    always_comb begin
        cin1 = 1'b0;
        cin2 = 1'b0;
        cin3 = 1'b0;
        case (mode)
            MAC_MODE_DUAL: begin
                cin1 = cout0;
                cin3 = cout2;
            end
            MAC_MODE_QUAD: begin
                cin1 = cout0;
                cin2 = cout1;
                cin3 = cout2;
            end
            default: ;
        endcase
    end

    mac_acc_lane_adder #(.W(MAC_ACC_WIDTH)) u_lane0 (
        .a(acc0), .b(C0_in), .cin(1'b0), .sum(sum0), .cout(cout0), .cmsb(cmsb0));
    mac_acc_lane_adder #(.W(MAC_ACC_WIDTH)) u_lane1 (
        .a(acc1), .b(C1_in), .cin(cin1), .sum(sum1), .cout(cout1), .cmsb(cmsb1));
    mac_acc_lane_adder #(.W(MAC_ACC_WIDTH)) u_lane2 (
        .a(acc2), .b(C2_in), .cin(cin2), .sum(sum2), .cout(cout2), .cmsb(cmsb2));
    mac_acc_lane_adder #(.W(MAC_ACC_WIDTH)) u_lane3 (
        .a(acc3), .b(C3_in), .cin(cin3), .sum(sum3), .cout(cout3), .cmsb(cmsb3));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc0       <= '0;
            acc1       <= '0;
            acc2       <= '0;
            acc3       <= '0;
            acc_count  <= '0;
            cfg_active <= '0;
            valid_out  <= 1'b0;
        end else begin
            valid_out <= fire;
            if (do_load || (do_beat && !do_add)) begin
                acc0 <= C0_in;
                acc1 <= C1_in;
                acc2 <= C2_in;
                acc3 <= C3_in;
            end else if (do_add) begin
                acc0 <= sum0;
                acc1 <= sum1;
                acc2 <= sum2;
                acc3 <= sum3;
            end else if (do_clear) begin
                acc0 <= '0;
                acc1 <= '0;
                acc2 <= '0;
                acc3 <= '0;
            end
            if (do_load) begin
                acc_count  <= MAC_CNT_WIDTH'(1);
                cfg_active <= cfg;
            end else if (do_beat) begin
                if (acc_count != '1) acc_count <= acc_count + MAC_CNT_WIDTH'(1);
            end else if (do_clear) begin
                acc_count <= '0;
            end
        end
    end

`ifdef MAC_ACC_OVERFLOW_EN
    logic [3:0] lane_ov, seg_mask;

    always_comb begin
        if (cfg_active[MAC_CFG_SIGNED_BIT])
            lane_ov = {cout3 ^ cmsb3, cout2 ^ cmsb2, cout1 ^ cmsb1, cout0 ^ cmsb0};
        else
            lane_ov = {cout3, cout2, cout1, cout0};
        case (mode)
            MAC_MODE_DUAL: seg_mask = 4'b1010;
            MAC_MODE_QUAD: seg_mask = 4'b1000;
            default:       seg_mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     ovf <= 4'b0000;
        else if (do_load || do_clear) ovf <= 4'b0000;
        else if (do_add)              ovf <= ovf | (lane_ov & seg_mask);
    end
`else
    logic ovf_unused;
    assign ovf_unused = ^{cout3, cmsb0, cmsb1, cmsb2, cmsb3};
`endif

endmodule

// File: tb/tb_mac_accumulator_block.sv
// Directed self-checking bench for mac_accumulator_block; ovf checks are
// compiled in when MAC_ACC_OVERFLOW_EN is defined.
module tb_mac_accumulator_block;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  cfg;
    logic        valid_in;
    logic        clear;
    logic [31:0] c0, c1, c2, c3;
    logic [31:0] acc0, acc1, acc2, acc3;
    logic        valid_out;
    logic [7:0]  acc_count;
    logic [3:0]  cfg_active;
    logic        fsm_state;
`ifdef MAC_ACC_OVERFLOW_EN
    logic [3:0]  ovf;
`endif
    logic [127:0] acc_all;
    logic [127:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    assign acc_all = {acc3, acc2, acc1, acc0};

    mac_accumulator_block dut (
        .clk(clk), .rst(rst), .en(en), .cfg(cfg), .valid_in(valid_in), .clear(clear),
        .C0_in(c0), .C1_in(c1), .C2_in(c2), .C3_in(c3),
        .acc0(acc0), .acc1(acc1), .acc2(acc2), .acc3(acc3),
        .valid_out(valid_out), .acc_count(acc_count), .cfg_active(cfg_active),
        .fsm_state(fsm_state)
`ifdef MAC_ACC_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then land 1 time unit after the rising edge.
    task automatic drive(input logic e, input logic v, input logic clr, input logic [3:0] cf,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        en = e; valid_in = v; clear = clr; cfg = cf;
        c0 = d0; c1 = d1; c2 = d2; c3 = d3;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h11, 32'h22, 32'h33, 32'h44);
        @(posedge clk);
        #1;
        check("rst_acc", acc_all, '0);
        check("rst_cnt", 128'(acc_count), 128'd0);
        check("rst_cfg", 128'(cfg_active), 128'd0);
        check("rst_vld", 128'(valid_out), 128'd0);
        check("rst_fsm", 128'(fsm_state), 128'd0);
`ifdef MAC_ACC_OVERFLOW_EN
        check("rst_ovf", 128'(ovf), 128'd0);
`endif
        rst = 1'b1;

        // single-mode signed mac
        exp_q.push_back({32'd4, 32'd3, 32'd2, 32'd1});
        exp_q.push_back({32'd3, 32'd2, 32'd1, 32'd0});
        drive(1'b1, 1'b1, 1'b0, 4'b1100, 32'd1, 32'd2, 32'd3, 32'd4);
        check("t1_load_acc", acc_all, exp_q.pop_front());
        check("t1_load_vld", 128'(valid_out), 128'd1);
        check("t1_load_cnt", 128'(acc_count), 128'd1);
        check("t1_cfg", 128'(cfg_active), 128'hC);
        drive(1'b1, 1'b1, 1'b0, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t1_add_acc", acc_all, exp_q.pop_front());
        check("t1_add_vld", 128'(valid_out), 128'd1);
        check("t1_add_cnt", 128'(acc_count), 128'd2);
`ifdef MAC_ACC_OVERFLOW_EN
        check("t1_ovf", 128'(ovf), 128'd0);
`endif
        drive(1'b1, 1'b0, 1'b0, 4'b1100, 32'd9, 32'd9, 32'd9, 32'd9);
        check("t1_idle_vld", 128'(valid_out), 128'd0);
        check("t1_idle_acc", acc_all, {32'd3, 32'd2, 32'd1, 32'd0});

        // clear alone
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
        check("clr_acc", acc_all, '0);
        check("clr_cnt", 128'(acc_count), 128'd0);
        check("clr_fsm", 128'(fsm_state), 128'd0);

        // dual-mode carry: no lane1 -> lane2 carry
        drive(1'b1, 1'b1, 1'b0, 4'b0101, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'b0101, 32'd1, 32'd0, 32'd1, 32'd0);
        check("dual_acc", acc_all, {32'd1, 32'd0, 32'd1, 32'd0});
        check("dual_cfg", 128'(cfg_active), 128'h5);
`ifdef MAC_ACC_OVERFLOW_EN
        check("dual_ovf", 128'(ovf), 128'd0);
`endif

        // quad wrap
        drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 1'b0, 4'b0110, 32'd1, 32'd0, 32'd0, 32'd0);
        check("quad_acc", acc_all, '0);
`ifdef MAC_ACC_OVERFLOW_EN
        check("quad_ovf", 128'(ovf), 128'h8);
`endif

        // cfg change ignored in ACC
        drive(1'b1, 1'b1, 1'b0, 4'b0101, 32'd5, 32'd0, 32'd0, 32'd0);
        check("cfgchg_acc", acc_all, {32'd0, 32'd0, 32'd0, 32'd5});
        check("cfgchg_cfg", 128'(cfg_active), 128'h6);
        check("cfgchg_cnt", 128'(acc_count), 128'd3);
`ifdef MAC_ACC_OVERFLOW_EN
        check("cfgchg_ovf", 128'(ovf), 128'h8);
`endif

        // clear + valid_in in the same cycle
        drive(1'b1, 1'b1, 1'b1, 4'b0101, 32'd7, 32'd8, 32'd0, 32'd0);
        check("clrld_acc", acc_all, {32'd0, 32'd0, 32'd8, 32'd7});
        check("clrld_cnt", 128'(acc_count), 128'd1);
        check("clrld_cfg", 128'(cfg_active), 128'h5);
        check("clrld_fsm", 128'(fsm_state), 128'd1);
`ifdef MAC_ACC_OVERFLOW_EN
        check("clrld_ovf", 128'(ovf), 128'd0);
`endif

        // en=0 freezes everything, including clear and valid_in
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 4'b1110, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD);
            check("frz_vld", 128'(valid_out), 128'd0);
        end
        check("frz_acc", acc_all, {32'd0, 32'd0, 32'd8, 32'd7});
        check("frz_cnt", 128'(acc_count), 128'd1);
        check("frz_cfg", 128'(cfg_active), 128'h5);

        // mul mode beats replace the accumulator
        drive(1'b1, 1'b1, 1'b1, 4'b0000, 32'd10, 32'd20, 32'd30, 32'd40);
        check("mul1_acc", acc_all, {32'd40, 32'd30, 32'd20, 32'd10});
        drive(1'b1, 1'b1, 1'b0, 4'b0100, 32'd1, 32'd1, 32'd1, 32'd1);
        check("mul2_acc", acc_all, {32'd1, 32'd1, 32'd1, 32'd1});
        check("mul2_cnt", 128'(acc_count), 128'd2);
        check("mul2_cfg", 128'(cfg_active), 128'h0);

        // asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check("arst_acc", acc_all, '0);
        check("arst_cnt", 128'(acc_count), 128'd0);
        check("arst_cfg", 128'(cfg_active), 128'd0);
        check("arst_vld", 128'(valid_out), 128'd0);
        check("arst_fsm", 128'(fsm_state), 128'd0);
        #1;
        rst = 1'b1;

        // first beat after reset is a load; then count saturates
        drive(1'b1, 1'b1, 1'b0, 4'b0100, 32'd1, 32'd0, 32'd0, 32'd0);
        check("post_rst_cnt", 128'(acc_count), 128'd1);
        check("post_rst_cfg", 128'(cfg_active), 128'h4);
        check("post_rst_acc", acc_all, {32'd0, 32'd0, 32'd0, 32'd1});
        for (int i = 1; i < 300; i++)
            drive(1'b1, 1'b1, 1'b0, 4'b0100, 32'd1, 32'd0, 32'd0, 32'd0);
        check("sat_cnt", 128'(acc_count), 128'd255);
        check("sat_acc", acc_all, {32'd0, 32'd0, 32'd0, 32'd300});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
